// File: rtl/serial_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : serial_pattern_detector
// Description : Serial N-bit pattern detector (overlapping matches) with a
//               fill FSM, saturating match counter and sticky saturation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_detector #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter int           COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    input  logic               clear,
    output logic [N-1:0]       history,
    output logic               primed,
    output logic               match,
    output logic [COUNT_W-1:0] match_count,
    output logic               sat
);

    localparam int                   c_fill_w  = $clog2(N + 1);
    localparam logic [c_fill_w-1:0]  c_fill_one = c_fill_w'(1);
    localparam logic [c_fill_w-1:0]  c_fill_nm1 = c_fill_w'(N - 1);
    localparam logic [COUNT_W-1:0]   c_cnt_one  = COUNT_W'(1);
    localparam logic [COUNT_W-1:0]   c_cnt_max  = '1;
    localparam logic [COUNT_W-1:0]   c_cnt_nm1  = c_cnt_max - c_cnt_one;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_PRIMED  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_fill_w-1:0] r_fill;
    logic [c_fill_w-1:0] w_fill_nxt;
    logic [N-1:0]        r_hist;
    logic [N-1:0]        w_hist_nxt;
    logic                r_match;
    logic                w_match_nxt;
    logic [COUNT_W-1:0]  r_cnt;
    logic                r_sat;

    assign w_hist_nxt = {r_hist[N-2:0], din};

    // At least N-1 bits already held means this accepted bit completes a full window.
    assign w_match_nxt = din_valid && (r_fill >= c_fill_nm1) && (w_hist_nxt == PATTERN);

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        case (r_state)
            ST_EMPTY: begin
                if (din_valid) begin
                    w_fill_nxt  = c_fill_one;
                    w_state_nxt = ST_FILLING;
                end
            end
            ST_FILLING: begin
                if (din_valid) begin
                    w_fill_nxt = r_fill + c_fill_one;
                    if (r_fill == c_fill_nm1) begin
                        w_state_nxt = ST_PRIMED;
                    end
                end
            end
            ST_PRIMED: begin
                w_state_nxt = ST_PRIMED;
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_fill_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist  <= '0;
            r_match <= 1'b0;
        end else begin
            if (din_valid) begin
                r_hist <= w_hist_nxt;
            end
            r_match <= w_match_nxt;
        end
    end

    // clear wins over a coincident increment; the match pulse itself is unaffected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (clear) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_match_nxt) begin
            if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + c_cnt_one;
                if (r_cnt == c_cnt_nm1) begin
                    r_sat <= 1'b1;
                end
            end else begin
                r_sat <= 1'b1;
            end
        end
    end

    assign history     = r_hist;
    assign primed      = (r_state == ST_PRIMED);
    assign match       = r_match;
    assign match_count = r_cnt;
    assign sat         = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_pattern_detector
// Description : Self-checking bench: three detector configurations driven by a
//               shared directed stream, checked against a bit-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_detector;

    logic clk;
    logic reset;
    logic din;
    logic din_valid;
    logic clear;

    logic [3:0] hist [3];
    logic       prim [3];
    logic       mtch [3];
    logic [7:0] cnt  [3];
    logic       satf [3];
    logic [3:0] cnt2_narrow;

    int errors = 0;
    int checks = 0;

    serial_pattern_detector #(.N(4), .PATTERN(4'b1011), .COUNT_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
        .history(hist[0]), .primed(prim[0]), .match(mtch[0]),
        .match_count(cnt[0]), .sat(satf[0])
    );

    serial_pattern_detector #(.N(4), .PATTERN(4'b0000), .COUNT_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
        .history(hist[1]), .primed(prim[1]), .match(mtch[1]),
        .match_count(cnt[1]), .sat(satf[1])
    );

    serial_pattern_detector #(.N(4), .PATTERN(4'b1011), .COUNT_W(4)) u_dut2 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
        .history(hist[2]), .primed(prim[2]), .match(mtch[2]),
        .match_count(cnt2_narrow), .sat(satf[2])
    );
    assign cnt[2] = {4'b0000, cnt2_narrow};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: window of the last 4 accepted bits, accepted-bit tally,
    // and a min()-saturated match tally per configuration.
    int pat  [3] = '{11, 0, 11};
    int cmax [3] = '{255, 255, 15};
    int m_hist [3] = '{0, 0, 0};
    int m_nacc [3] = '{0, 0, 0};
    int m_cnt  [3] = '{0, 0, 0};
    bit m_match[3] = '{0, 0, 0};
    bit m_sat  [3] = '{0, 0, 0};

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_hist[k] = 0; m_nacc[k] = 0; m_cnt[k] = 0; m_match[k] = 0; m_sat[k] = 0;
            end else begin
                m_match[k] = 0;
                if (din_valid) begin
                    m_hist[k]  = ((m_hist[k] * 2) + int'(din)) % 16;
                    m_match[k] = (m_nacc[k] >= 3) && (m_hist[k] == pat[k]);
                    m_nacc[k]  = m_nacc[k] + 1;
                end
                if (clear) begin
                    m_cnt[k] = 0;
                    m_sat[k] = 0;
                end else if (m_match[k]) begin
                    m_cnt[k] = (m_cnt[k] + 1 > cmax[k]) ? cmax[k] : m_cnt[k] + 1;
                    if (m_cnt[k] == cmax[k]) m_sat[k] = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model%0d.history", k), int'(hist[k]), m_hist[k]);
            chk($sformatf("model%0d.primed", k),  int'(prim[k]), int'(m_nacc[k] >= 4));
            chk($sformatf("model%0d.match", k),   int'(mtch[k]), int'(m_match[k]));
            chk($sformatf("model%0d.count", k),   int'(cnt[k]),  m_cnt[k]);
            chk($sformatf("model%0d.sat", k),     int'(satf[k]), int'(m_sat[k]));
        end
    end

    // Drives one edge; inputs change 1 time unit after the edge, sampling happens there too.
    task automatic step(input bit v, input bit d, input bit c);
        din_valid = v;
        din       = d;
        clear     = c;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic send(input bit d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; din = 1'b0; din_valid = 1'b0; clear = 1'b0;

        // 1: reset with no clock edge
        #1 reset = 1'b1;
        #1;
        chk("rst.history", int'(hist[0]), 0);
        chk("rst.primed",  int'(prim[0]), 0);
        chk("rst.match",   int'(mtch[0]), 0);
        chk("rst.count",   int'(cnt[0]),  0);
        chk("rst.sat",     int'(satf[0]), 0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        step(1'b0, 1'b1, 1'b0);
        chk("idle.primed", int'(prim[0]), 0);

        // 2: basic detect
        send(1); send(0); send(1);
        chk("basic.nomatch3", int'(mtch[0]), 0);
        send(1);
        chk("basic.history", int'(hist[0]), 11);
        chk("basic.primed",  int'(prim[0]), 1);
        chk("basic.match",   int'(mtch[0]), 1);
        chk("basic.count",   int'(cnt[0]),  1);
        step(1'b0, 1'b1, 1'b0);
        chk("basic.drop",    int'(mtch[0]), 0);
        chk("basic.hold",    int'(cnt[0]),  1);

        // 3: overlap
        pulse_reset();
        send(1); send(0); send(1); send(1);
        chk("ovl.m4", int'(mtch[0]), 1);
        send(0);
        chk("ovl.m5", int'(mtch[0]), 0);
        send(1);
        chk("ovl.m6", int'(mtch[0]), 0);
        send(1);
        chk("ovl.m7",      int'(mtch[0]), 1);
        chk("ovl.count",   int'(cnt[0]),  2);
        chk("ovl.history", int'(hist[0]), 11);

        // 4: valid gaps
        pulse_reset();
        send(1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, i[0], 1'b0);
            chk("gap.match", int'(mtch[0]), 0);
        end
        send(0); send(1); send(1);
        chk("gap.final",   int'(mtch[0]), 1);
        chk("gap.history", int'(hist[0]), 11);
        chk("gap.count",   int'(cnt[0]),  1);

        // 5a: all-zero pattern
        pulse_reset();
        send(0); send(0); send(0);
        chk("zero.m3",      int'(mtch[1]), 0);
        chk("zero.primed3", int'(prim[1]), 0);
        send(0);
        chk("zero.m4", int'(mtch[1]), 1);
        send(0);
        chk("zero.m5",    int'(mtch[1]), 1);
        chk("zero.count", int'(cnt[1]),  2);

        // 5b: reset mid-stream discards partial fill
        pulse_reset();
        send(1); send(0); send(1);
        #2 pulse_reset();
        chk("mid.reset.history", int'(hist[0]), 0);
        send(1);
        chk("mid.match",  int'(mtch[0]), 0);
        chk("mid.primed", int'(prim[0]), 0);

        // 6: saturation on the 4-bit counter
        pulse_reset();
        for (int i = 1; i <= 16; i++) begin
            if (i == 1) begin
                send(1); send(0); send(1); send(1);
            end else begin
                send(0); send(1); send(1);
            end
            if (i == 14) begin
                chk("sat.c14", int'(cnt[2]),  14);
                chk("sat.s14", int'(satf[2]), 0);
            end
            if (i == 15) begin
                chk("sat.c15", int'(cnt[2]),  15);
                chk("sat.s15", int'(satf[2]), 1);
            end
            if (i == 16) begin
                chk("sat.c16", int'(cnt[2]),  15);
                chk("sat.s16", int'(satf[2]), 1);
            end
        end
        send(0); send(1);
        step(1'b1, 1'b1, 1'b1);
        chk("clr.match", int'(mtch[2]), 1);
        chk("clr.count", int'(cnt[2]),  0);
        chk("clr.sat",   int'(satf[2]), 0);
        chk("clr.count8", int'(cnt[0]), 0);
        send(0); send(1); send(1);
        chk("clr.recount", int'(cnt[2]), 1);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
